// File: rtl/and_operand_skid_pkg.sv
// Shared definitions for the AND stage input buffer: occupancy states and operand width.
package and_operand_skid_pkg;

    localparam int AND_WIDTH = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/and_operand_skid.sv
// Two-entry valid/ready skid buffer feeding operand pairs to the AND stage.
// in_ready is registered so upstream timing never sees out_ready combinationally.
module and_operand_skid
    import and_operand_skid_pkg::*;
#(
    parameter int WIDTH   = AND_WIDTH,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_a,
    output logic [WIDTH-1:0]   out_b,
    output logic [COUNT_W-1:0] xfer_count
);

    skid_state_t        state_reg, state_next;
    logic [WIDTH-1:0]   main_a_reg, main_b_reg;
    logic [WIDTH-1:0]   skid_a_reg, skid_b_reg;
    logic               in_ready_reg;
    logic [COUNT_W-1:0] count_reg;

    logic in_fire, out_fire;
    logic load_main, load_skid, main_from_skid;

    assign in_fire  = in_valid & in_ready_reg;
    assign out_fire = out_valid & out_ready;

    always_comb begin
        state_next     = state_reg;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_reg)
            EMPTY: begin
                if (in_fire) begin
                    load_main  = 1'b1;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (in_fire) begin
                    load_skid  = 1'b1;
                    state_next = FULL;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_from_skid = 1'b1;
                    state_next     = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // in_ready for next cycle is decided from the next state, keeping it a pure flop output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= EMPTY;
            in_ready_reg <= 1'b1;
            main_a_reg   <= '0;
            main_b_reg   <= '0;
            skid_a_reg   <= '0;
            skid_b_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            in_ready_reg <= (state_next != FULL);
            if (load_main) begin
                main_a_reg <= in_a;
                main_b_reg <= in_b;
            end else if (main_from_skid) begin
                main_a_reg <= skid_a_reg;
                main_b_reg <= skid_b_reg;
            end
            if (load_skid) begin
                skid_a_reg <= in_a;
                skid_b_reg <= in_b;
            end
            if (in_fire) begin
                count_reg <= count_reg + COUNT_W'(1);
            end
        end
    end

    assign in_ready   = in_ready_reg;
    assign out_valid  = (state_reg != EMPTY);
    assign out_a      = main_a_reg;
    assign out_b      = main_b_reg;
    assign xfer_count = count_reg;

endmodule

// File: tb/tb_and_operand_skid.sv
// Randomized and directed bench for and_operand_skid against a FIFO-queue reference model.
module tb_and_operand_skid;

    localparam int WIDTH   = 2;
    localparam int COUNT_W = 4;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } pair_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a, in_b;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_a, out_b;
    logic [COUNT_W-1:0] xfer_count;

    and_operand_skid #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_a      (out_a),
        .out_b      (out_b),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    int    checks_total  = 0;
    int    checks_passed = 0;
    pair_t model_q[$];
    int    model_count = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp) checks_passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Compare DUT outputs against the reference queue (called away from the clock edge).
    task automatic check_outputs();
        check("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        check("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
        check("xfer_count", 32'(xfer_count), 32'(model_count % (1 << COUNT_W)));
        if (model_q.size() > 0) begin
            check("out_a", 32'(out_a), 32'(model_q[0].a));
            check("out_b", 32'(out_b), 32'(model_q[0].b));
            check("and_result", 32'(out_a & out_b), 32'(model_q[0].a & model_q[0].b));
        end
    endtask

    // One clock: check, drive, predict, advance. Returns whether the input pair was taken.
    task automatic step(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic r, output logic accepted);
        logic do_in, do_out;
        pair_t p;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        out_ready = r;
        do_in  = v && (model_q.size() < 2);
        do_out = r && (model_q.size() > 0);
        @(posedge clk);
        if (do_out) void'(model_q.pop_front());
        if (do_in) begin
            p.a = a;
            p.b = b;
            model_q.push_back(p);
            model_count++;
        end
        accepted = do_in;
        $display("cycle v=%0b a=%0d b=%0d r=%0b in_fire=%0b out_fire=%0b occ=%0d",
                 v, a, b, r, do_in, do_out, model_q.size());
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_xfer_count", 32'(xfer_count), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        check("rst_out_b", 32'(out_b), 32'd0);
        model_q.delete();
        model_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic acc;
        logic hold_v;
        logic [WIDTH-1:0] hold_a, hold_b;
        logic r;
        rst_n = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
        #2;
        do_reset();

        // Streaming 3/1, 2/3, 1/1 with out_ready held high
        step(1, 3, 1, 1, acc);
        step(1, 2, 3, 1, acc);
        step(1, 1, 1, 1, acc);
        step(0, 0, 0, 1, acc);
        check("stream_count", 32'(xfer_count), 32'd3);
        step(0, 0, 0, 1, acc);
        step(0, 0, 0, 1, acc);

        // Backpressure: 3/3, 2/2 fill the buffer, 1/1 is held until space opens
        step(1, 3, 3, 0, acc);
        step(1, 2, 2, 0, acc);
        step(1, 1, 1, 0, acc);
        check("bp_third_refused", 32'(acc), 32'd0);
        step(1, 1, 1, 0, acc);
        check("bp_still_refused", 32'(acc), 32'd0);
        step(1, 1, 1, 1, acc);
        check("bp_third_refused_full", 32'(acc), 32'd0);
        step(1, 1, 1, 1, acc);
        check("bp_third_taken", 32'(acc), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, acc);

        // Simultaneous fire while one entry held
        step(1, 2, 1, 0, acc);
        step(1, 3, 2, 1, acc);
        step(1, 1, 3, 1, acc);
        step(0, 0, 0, 1, acc);
        step(0, 0, 0, 1, acc);

        // Mid-stream reset with both entries held
        step(1, 1, 2, 0, acc);
        step(1, 2, 1, 0, acc);
        step(0, 0, 0, 0, acc);
        check("pre_reset_full", 32'(in_ready), 32'd0);
        do_reset();
        step(0, 0, 0, 1, acc);

        // Counter wrap: 17 accepted pairs on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) step(1, WIDTH'(i), WIDTH'(i + 1), 1, acc);
        step(0, 0, 0, 1, acc);
        check("wrap_count", 32'(xfer_count), 32'd1);

        // Random traffic; upstream holds a pair until it is taken
        hold_v = 1'b0; hold_a = '0; hold_b = '0;
        for (int i = 0; i < 10000; i++) begin
            if (!hold_v && ($urandom_range(0, 3) != 0)) begin
                hold_v = 1'b1;
                hold_a = WIDTH'($urandom);
                hold_b = WIDTH'($urandom);
            end
            r = ($urandom_range(0, 2) != 0);
            step(hold_v, hold_a, hold_b, r, acc);
            if (acc) hold_v = 1'b0;
        end
        for (int i = 0; i < 3; i++) step(0, 0, 0, 1, acc);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
